// File: rtl/regfile.sv
// MIPS32 general-purpose register file: 2^ADDR_W x DATA_W, $0 hardwired to zero,
// two combinational read ports, one edge-committed write port.
// Optional write-back-to-decode bypass: define REGFILE_WB_BYPASS_EN.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam int NREGS = 1 << ADDR_W;

    // No valid/ready handshake: a read is answered in the cycle it is
    // presented, and a write is committed on the rising edge it is presented at.
    logic [DATA_W-1:0] regs [NREGS];

    // Reset wins over a same-edge write; writes to $0 are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    logic hit1;
    logic hit2;

`ifdef REGFILE_WB_BYPASS_EN
    assign hit1 = we && (waddr != '0) && (waddr == raddr1);
    assign hit2 = we && (waddr != '0) && (waddr == raddr2);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    // Priority: reset, disabled port, $0, bypass, stored value.
    always_comb begin
        rdata1 = '0;
        if (rst && re1 && (raddr1 != '0)) begin
            rdata1 = hit1 ? wdata : regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst && re2 && (raddr2 != '0)) begin
            rdata2 = hit2 ? wdata : regs[raddr2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed scenarios with literal expectations, then random
// traffic checked against an array-based reference model.
module tb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
`ifdef REGFILE_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model and scoreboard
    logic [DATA_W-1:0] model [32];
    logic [DATA_W-1:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [DATA_W-1:0] model_read(input logic e, input logic [ADDR_W-1:0] a);
        if (!rst || !e || a == 0) return '0;
        if (BYP && we && waddr == a) return wdata;
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        logic [DATA_W-1:0] e;
        exp_q.push_back(exp);
        e = exp_q.pop_front();
        n_cmp++;
        assert (got === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, e);
        end
    endtask

    // driver tasks
    task automatic apply(input logic r, input logic w, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic e1, input logic [ADDR_W-1:0] a1,
                         input logic e2, input logic [ADDR_W-1:0] a2);
        rst = r; we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    endtask

    task automatic end_cycle();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (we && waddr != 0) begin
            model[waddr] = wdata;
        end
        #1;
    endtask

    task automatic cyc(input string tag, input logic r, input logic w, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input logic e1, input logic [ADDR_W-1:0] a1,
                       input logic e2, input logic [ADDR_W-1:0] a2,
                       input logic [DATA_W-1:0] x1, input logic [DATA_W-1:0] x2);
        apply(r, w, wa, wd, e1, a1, e2, a2);
        #3;
        check({tag, ".p1"}, rdata1, x1);
        check({tag, ".p2"}, rdata2, x2);
        end_cycle();
    endtask

    initial begin
        apply(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
        @(posedge clk);
        #1;

        // reset clear, reads forced to zero during reset
        cyc("rst_hold",  0, 0, 0, 32'h0,        1, 5, 1, 7, 32'h0, 32'h0);
        cyc("wr5",       1, 1, 5, 32'hDEADBEEF, 1, 5, 0, 5, BYP ? 32'hDEADBEEF : 32'h0, 32'h0);
        cyc("rd5_pre",   1, 0, 0, 32'h0,        1, 5, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF);
        cyc("rst_rd5",   0, 0, 0, 32'h0,        1, 5, 1, 5, 32'h0, 32'h0);
        cyc("rd5_post",  1, 0, 0, 32'h0,        1, 5, 1, 5, 32'h0, 32'h0);

        // $0 hardwired
        cyc("w0",        1, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 32'h0, 32'h0);
        cyc("r0",        1, 0, 0, 32'h0,        1, 0, 1, 0, 32'h0, 32'h0);

        // basic write/read, disabled port
        cyc("w3",        1, 1, 3, 32'h00001234, 0, 3, 0, 3, 32'h0, 32'h0);
        cyc("r3",        1, 0, 0, 32'h0,        1, 3, 1, 3, 32'h00001234, 32'h00001234);
        cyc("r3_re2off", 1, 0, 0, 32'h0,        1, 3, 0, 3, 32'h00001234, 32'h0);

        // same-cycle read of the write target
        cyc("w7a",       1, 1, 7, 32'h11111111, 0, 0, 0, 0, 32'h0, 32'h0);
        cyc("w7b",       1, 1, 7, 32'h22222222, 1, 7, 1, 3,
            BYP ? 32'h22222222 : 32'h11111111, 32'h00001234);
        cyc("r7",        1, 0, 0, 32'h0,        1, 7, 1, 7, 32'h22222222, 32'h22222222);

        // reset vs write collision
        cyc("rst_wr9",   0, 1, 9, 32'hA5A5A5A5, 1, 9, 1, 9, 32'h0, 32'h0);
        cyc("r9",        1, 0, 0, 32'h0,        1, 9, 1, 9, 32'h0, 32'h0);
        cyc("r7_clr",    1, 0, 0, 32'h0,        1, 7, 1, 3, 32'h0, 32'h0);

        // independent ports
        cyc("w1",        1, 1, 1, 32'h0000000A, 0, 0, 0, 0, 32'h0, 32'h0);
        cyc("w2",        1, 1, 2, 32'h0000000B, 1, 1, 1, 2, 32'h0000000A, BYP ? 32'h0000000B : 32'h0);
        cyc("rd12",      1, 0, 0, 32'h0,        1, 1, 1, 2, 32'h0000000A, 32'h0000000B);
        cyc("rd21",      1, 0, 0, 32'h0,        1, 2, 1, 1, 32'h0000000B, 32'h0000000A);

        // random traffic against the model
        for (int n = 0; n < 500; n++) begin
            logic [ADDR_W-1:0] wa;
            logic [ADDR_W-1:0] a1;
            logic [ADDR_W-1:0] a2;
            wa = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 31)) : ADDR_W'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : ADDR_W'($urandom_range(0, 7));
            apply(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)), wa, $urandom,
                  ($urandom_range(0, 4) != 0), a1, ($urandom_range(0, 4) != 0), a2);
            #3;
            check("rnd.p1", rdata1, model_read(re1, raddr1));
            check("rnd.p2", rdata2, model_read(re2, raddr2));
            end_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the five-stage MIPS32 pipeline: the responder for the decode stage's two read requests, and the target of the write-back stage's single write. It holds 32 × 32-bit registers with `$0` hardwired to zero. It answers both read ports combinationally in the same cycle, and commits writes on the rising clock edge.

## Interface
Parameters:
- `DATA_W`, 32: register width.
- `ADDR_W`, 5: register address width; number of registers is 2^ADDR_W.

Ports:
- `clk`  in  1: pipeline clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-low reset. Sampled on the rising edge of `clk`; while low, all registers clear.
- `we`  in  1: write enable from write-back.
- `waddr`  in  ADDR_W: write register number.
- `wdata`  in  DATA_W: write data.
- `re1`  in  1: read enable, port 1 (driven by decode `reg1_read_o`).
- `raddr1`  in  ADDR_W: read address, port 1 (decode `reg1_addr_o`).
- `rdata1`  out  DATA_W: read data, port 1 (to decode `reg1_data_i`).
- `re2`  in  1: read enable, port 2.
- `raddr2`  in  ADDR_W: read address, port 2.
- `rdata2`  out  DATA_W: read data, port 2.

## Operation
- Storage is an array `regs[0..31]` of DATA_W bits.
- **Write.** On a rising edge with `rst`=1, `we`=1 and `waddr`≠0, `regs[waddr]` ← `wdata`.
  - A write to address 0 is silently discarded.
  - When `we`=0, no register changes.
- **Reset.** On a rising edge with `rst`=0, every `regs[i]` ← 0.
  - Reset takes priority over a simultaneous write; that write is lost.
- **Read.** Each port is purely combinational, with the following priority (highest first):
  1. `rst`=0 → 0.
  2. Port enable (`re1`/`re2`) = 0 → 0.
  3. Address = 0 → 0.
  4. Bypass hit (see Configuration) → `wdata`.
  5. Otherwise → `regs[addr]`.
- Both ports are independent. The same address may be read on both ports at once, and both receive identical data.
- There are no handshakes and no stalls. Every read is answered in the cycle it is presented.

## Timing
- Read latency is zero cycles: a combinational path from `raddr*`/`re*` to `rdata*`.
- Write latency:
  - The data is in the array after the rising edge on which it is presented.
  - Without bypass, a read of that address shows the new value starting the cycle after the write.
  - With bypass, the new value is visible in the same cycle the write is presented.
- Reset values:
  - `rdata1` = `rdata2` = 0 throughout reset.
  - All `regs` are 0 from the first edge sampled with `rst`=0.
- Reset mid-operation: a write presented in the same cycle as the reset edge is not committed. Reads during reset return 0 regardless of bypass.
- Decode-stage forwarding from EX and MEM lies outside this block. This block covers only the write-back-to-decode hazard.

## Configuration
- Macro: `REGFILE_WB_BYPASS_EN`.
- **Defined:**
  - Condition: when `we`=1, `waddr`≠0, `re*`=1 and `raddr*`=`waddr`, the port returns `wdata` combinationally in the same cycle.
  - Effect: this covers an instruction in decode reading a register written back in the same cycle.
- **Undefined:**
  - The bypass path is absent, and reads always return `regs[addr]`.
  - In that case the program or an external stall must separate a write-back from a dependent decode by at least one cycle.

## Test plan
- **Reset clear:** write `32'hDEADBEEF` to `$5`, assert `rst`=0 for one edge, then read `$5` → 0. During reset, `rdata1`/`rdata2` = 0 even with `re`=1.
- **`$0` hardwired:** `we`=1, `waddr`=0, `wdata`=`32'hFFFFFFFF`; next cycle read `raddr1`=0 with `re1`=1 → `rdata1`=0.
- **Basic write/read:** write `32'h00001234` to `$3`; next cycle `raddr1`=3 and `raddr2`=3 → both ports = `32'h00001234`. With `re2`=0, `rdata2`=0.
- **Same-cycle read of write target:** `$7` holds `32'h11111111`; present `we`=1, `waddr`=7, `wdata`=`32'h22222222` with `re1`=1, `raddr1`=7.
  - With `REGFILE_WB_BYPASS_EN` → `rdata1`=`32'h22222222`.
  - Without it → `32'h11111111` that cycle, then `32'h22222222` the next cycle.
- **Reset vs write collision:** `rst`=0 with `we`=1, `waddr`=9, `wdata`=`32'hA5A5A5A5` on the same edge; after release, read `$9` → 0.
- **Independent ports:** `$1`=`32'h0000000A`, `$2`=`32'h0000000B`; `raddr1`=1, `raddr2`=2 in the same cycle → `rdata1`=`32'hA`, `rdata2`=`32'hB`. Swapping the addresses swaps the outputs in the same cycle.
